// File: rtl/barker_correlator.sv
// Barker-5 cyclic correlator: captures a frame on load, evaluates one lag per clock,
// then reports peak correlation, its lag and a threshold match; tracks frames and overruns.
module barker_correlator #(
  parameter int unsigned     N        = 5,
  parameter logic [N-1:0]    REF_CODE = 5'b11101,
  parameter int              THRESH   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         busy,
  output logic         result_valid,
  output logic [3:0]   corr_peak,
  output logic [2:0]   peak_lag,
  output logic         match,
  output logic [7:0]   frame_cnt,
  output logic         overrun
);

  localparam int unsigned CW = 4;
  localparam int unsigned LW = 3;
  localparam int unsigned PW = $clog2(N + 1);
  localparam logic signed [CW-1:0] THR = CW'(THRESH);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                state, state_n;
  logic [N-1:0]          frame, frame_n;
  logic [LW-1:0]         lag, lag_n;
  logic signed [CW-1:0]  best, best_n;
  logic [LW-1:0]         best_lag, best_lag_n;
  logic                  busy_n, result_valid_n, match_n, overrun_n;
  logic [3:0]            corr_peak_n;
  logic [2:0]            peak_lag_n;
  logic [7:0]            frame_cnt_n;

  logic [2*N-1:0]        ref_pair;
  logic [N-1:0]          ref_k;
  logic [N-1:0]          diff;
  logic [PW-1:0]         pc;
  logic signed [CW-1:0]  c_k;

  // Bipolar correlation of the held frame against REF_CODE rotated right by the current lag
  always_comb begin
    ref_pair = {REF_CODE, REF_CODE} >> lag;
    ref_k    = ref_pair[N-1:0];
    diff     = frame ^ ref_k;
    pc       = '0;
    for (int i = 0; i < int'(N); i++) begin
      pc = pc + PW'(diff[i]);
    end
    c_k = $signed(CW'(N)) - $signed(CW'({pc, 1'b0}));
  end

  // Next-state and next-output logic
  always_comb begin
    state_n        = state;
    frame_n        = frame;
    lag_n          = lag;
    best_n         = best;
    best_lag_n     = best_lag;
    busy_n         = busy;
    result_valid_n = 1'b0;
    corr_peak_n    = corr_peak;
    peak_lag_n     = peak_lag;
    match_n        = match;
    frame_cnt_n    = frame_cnt;
    overrun_n      = overrun;
    case (state)
      IDLE: begin
        if (load) begin
          frame_n     = data_in;
          frame_cnt_n = frame_cnt + 8'd1;
          lag_n       = '0;
          busy_n      = 1'b1;
          state_n     = COMPUTE;
        end
      end
      COMPUTE: begin
        if (load) overrun_n = 1'b1;
        // Strict greater-than keeps the lowest lag on ties
        if (lag == '0 || c_k > best) begin
          best_n     = c_k;
          best_lag_n = lag;
        end
        if (lag == LW'(N - 1)) state_n = DONE;
        else                   lag_n   = lag + LW'(1);
      end
      DONE: begin
        if (load) overrun_n = 1'b1;
        corr_peak_n    = best;
        peak_lag_n     = best_lag;
        match_n        = (best >= THR);
        result_valid_n = 1'b1;
        busy_n         = 1'b0;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame        <= '0;
      lag          <= '0;
      best         <= '0;
      best_lag     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      corr_peak    <= '0;
      peak_lag     <= '0;
      match        <= 1'b0;
      frame_cnt    <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      frame        <= frame_n;
      lag          <= lag_n;
      best         <= best_n;
      best_lag     <= best_lag_n;
      busy         <= busy_n;
      result_valid <= result_valid_n;
      corr_peak    <= corr_peak_n;
      peak_lag     <= peak_lag_n;
      match        <= match_n;
      frame_cnt    <= frame_cnt_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_barker_correlator.sv
// Scoreboard bench for barker_correlator: directed frames push hand-computed results,
// a negedge monitor pops and checks them whenever result_valid pulses.
module tb_barker_correlator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] data_in;
  logic       load;
  logic       busy, result_valid, match, overrun;
  logic [3:0] corr_peak;
  logic [2:0] peak_lag;
  logic [7:0] frame_cnt;

  barker_correlator dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .busy(busy),
    .result_valid(result_valid), .corr_peak(corr_peak), .peak_lag(peak_lag),
    .match(match), .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int peak;
    int lag;
    int m;
    int cnt;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        got = sbq.pop_front();
        chk("corr_peak", int'($signed(corr_peak)), got.peak);
        chk("peak_lag", int'(peak_lag), got.lag);
        chk("match", int'(match), got.m);
        chk("frame_cnt", int'(frame_cnt), got.cnt);
        chk("latency", cyc, got.cyc);
        chk("busy_at_result", int'(busy), 0);
      end
    end
  end

  // Caller sits on a negedge; load is sampled at the next posedge, result follows 6 edges later
  task automatic push_exp(input int pk, input int lg, input int m);
    exp_t e;
    exp_cnt = (exp_cnt + 1) % 256;
    e.peak = pk; e.lag = lg; e.m = m; e.cnt = exp_cnt; e.cyc = cyc + 7;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [4:0] d, input int pk, input int lg, input int m);
    push_exp(pk, lg, m);
    load    = 1'b1;
    data_in = d;
    @(negedge clk);
    load    = 1'b0;
    data_in = 5'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk(nm, sbq.size(), 0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_result_valid"}, int'(result_valid), 0);
    chk({nm, "_corr_peak"}, int'(corr_peak), 0);
    chk({nm, "_peak_lag"}, int'(peak_lag), 0);
    chk({nm, "_match"}, int'(match), 0);
    chk({nm, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({nm, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reset during COMPUTE aborts the frame, asynchronously
    load = 1'b1; data_in = 5'b11101;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (10) @(negedge clk);

    // Directed frames, back to back at one frame per 7 cycles
    send(5'b11101,  5, 0, 1);
    send(5'b11110,  5, 1, 1);
    send(5'b11011,  5, 4, 1);
    send(5'b00010, -1, 1, 0);
    send(5'b00000, -3, 0, 0);
    send(5'b11111,  3, 0, 0);
    send(5'b01110,  3, 1, 0);
    drain("drain_vectors");
    chk("held_corr_peak", int'($signed(corr_peak)), 3);
    chk("held_peak_lag", int'(peak_lag), 1);

    // Second load two cycles into COMPUTE is dropped and flags overrun
    chk("overrun_clear", int'(overrun), 0);
    push_exp(5, 3, 1);
    load = 1'b1; data_in = 5'b10111;
    @(negedge clk);
    load = 1'b0; data_in = 5'b00000;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    drain("drain_overrun");
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_frame_cnt", int'(frame_cnt), exp_cnt);
    repeat (5) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset clears overrun, then 256 frames wrap the counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("overrun_after_rst", int'(overrun), 0);
    for (int i = 0; i < 256; i++) send(5'b11101, 5, 0, 1);
    drain("drain_wrap");
    chk("frame_cnt_wrap", int'(frame_cnt), 0);
    chk("overrun_wrap", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
